// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite arbiter (axil_arbiter, axil_rr_picker).
package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } read_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Grant index width; a single-bit index is kept even for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rr_picker.sv
// Combinational requester picker: round-robin from last+1 with wrap, or
// lowest-index fixed priority when AXIL_ARB_FIXED_PRIO_EN is defined.
module axil_rr_picker #(
    parameter int NUM_S = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_S-1:0] req,
`ifndef AXIL_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] last,
`endif
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        grant   = '0;
        any_req = 1'b0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant   = IDX_W'(i);
                any_req = 1'b1;
            end
        end
`else
        for (int i = 1; i <= NUM_S; i++) begin
            if (!any_req && req[(int'(last) + i) % NUM_S]) begin
                grant   = IDX_W'((int'(last) + i) % NUM_S);
                any_req = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/axil_arbiter.sv
// NUM_S-to-1 AXI-Lite arbiter with independent write/read paths, one outstanding
// transaction each. Define AXIL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module axil_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_S      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic [NUM_S*ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [NUM_S*3-1:0]          s_axil_awprot,
    input  logic [NUM_S-1:0]            s_axil_awvalid,
    output logic [NUM_S-1:0]            s_axil_awready,
    input  logic [NUM_S*DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [NUM_S*STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic [NUM_S-1:0]            s_axil_wvalid,
    output logic [NUM_S-1:0]            s_axil_wready,
    output logic [NUM_S*2-1:0]          s_axil_bresp,
    output logic [NUM_S-1:0]            s_axil_bvalid,
    input  logic [NUM_S-1:0]            s_axil_bready,
    input  logic [NUM_S*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [NUM_S*3-1:0]          s_axil_arprot,
    input  logic [NUM_S-1:0]            s_axil_arvalid,
    output logic [NUM_S-1:0]            s_axil_arready,
    output logic [NUM_S*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [NUM_S*2-1:0]          s_axil_rresp,
    output logic [NUM_S-1:0]            s_axil_rvalid,
    input  logic [NUM_S-1:0]            s_axil_rready,

    output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
    output logic [2:0]                  m_axil_awprot,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [DATA_WIDTH-1:0]       m_axil_wdata,
    output logic [STRB_WIDTH-1:0]       m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
    output logic [2:0]                  m_axil_arprot,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);

    localparam int IDX_W = idx_width(NUM_S);

    write_state_t     w_state_q, w_state_d;
    read_state_t      r_state_q, r_state_d;
    logic [IDX_W-1:0] wgrant_q, wgrant_d;
    logic [IDX_W-1:0] rgrant_q, rgrant_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [IDX_W-1:0] w_pick, r_pick;
    logic             w_any, r_any;

`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] last_w_q, last_w_d;
    logic [IDX_W-1:0] last_r_q, last_r_d;
`endif

    axil_rr_picker #(.NUM_S(NUM_S), .IDX_W(IDX_W)) u_w_pick (
        .req     (s_axil_awvalid),
`ifndef AXIL_ARB_FIXED_PRIO_EN
        .last    (last_w_q),
`endif
        .grant   (w_pick),
        .any_req (w_any)
    );

    axil_rr_picker #(.NUM_S(NUM_S), .IDX_W(IDX_W)) u_r_pick (
        .req     (s_axil_arvalid),
`ifndef AXIL_ARB_FIXED_PRIO_EN
        .last    (last_r_q),
`endif
        .grant   (r_pick),
        .any_req (r_any)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wgrant_q  <= '0;
            rgrant_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_w_q  <= IDX_W'(NUM_S - 1);
            last_r_q  <= IDX_W'(NUM_S - 1);
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wgrant_q  <= wgrant_d;
            rgrant_q  <= rgrant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_w_q  <= last_w_d;
            last_r_q  <= last_r_d;
`endif
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wgrant_d  = wgrant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        last_w_d  = last_w_q;
`endif
        m_axil_awaddr  = '0;
        m_axil_awprot  = '0;
        m_axil_awvalid = 1'b0;
        m_axil_wdata   = '0;
        m_axil_wstrb   = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        s_axil_bresp   = '0;

        unique case (w_state_q)
            W_IDLE: begin
                if (w_any) begin
                    wgrant_d  = w_pick;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    last_w_d  = w_pick;
`endif
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_XFER;
                end
            end
            W_XFER: begin
                m_axil_awaddr  = s_axil_awaddr[wgrant_q*ADDR_WIDTH +: ADDR_WIDTH];
                m_axil_awprot  = s_axil_awprot[wgrant_q*3 +: 3];
                m_axil_awvalid = s_axil_awvalid[wgrant_q] & ~aw_done_q;
                s_axil_awready[wgrant_q] = m_axil_awready & ~aw_done_q;
                m_axil_wdata   = s_axil_wdata[wgrant_q*DATA_WIDTH +: DATA_WIDTH];
                m_axil_wstrb   = s_axil_wstrb[wgrant_q*STRB_WIDTH +: STRB_WIDTH];
                m_axil_wvalid  = s_axil_wvalid[wgrant_q] & ~w_done_q;
                s_axil_wready[wgrant_q] = m_axil_wready & ~w_done_q;
                // AW and W complete independently; move on once both are recorded.
                aw_done_d = aw_done_q | (m_axil_awvalid & m_axil_awready);
                w_done_d  = w_done_q | (m_axil_wvalid & m_axil_wready);
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axil_bvalid[wgrant_q]       = m_axil_bvalid;
                s_axil_bresp[wgrant_q*2 +: 2] = m_axil_bresp;
                m_axil_bready                 = s_axil_bready[wgrant_q];
                if (m_axil_bvalid && s_axil_bready[wgrant_q]) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rgrant_d  = rgrant_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        last_r_d  = last_r_q;
`endif
        m_axil_araddr  = '0;
        m_axil_arprot  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;

        unique case (r_state_q)
            R_IDLE: begin
                if (r_any) begin
                    rgrant_d  = r_pick;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    last_r_d  = r_pick;
`endif
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axil_araddr  = s_axil_araddr[rgrant_q*ADDR_WIDTH +: ADDR_WIDTH];
                m_axil_arprot  = s_axil_arprot[rgrant_q*3 +: 3];
                m_axil_arvalid = s_axil_arvalid[rgrant_q];
                s_axil_arready[rgrant_q] = m_axil_arready;
                if (m_axil_arvalid && m_axil_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                s_axil_rvalid[rgrant_q]                        = m_axil_rvalid;
                s_axil_rdata[rgrant_q*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
                s_axil_rresp[rgrant_q*2 +: 2]                  = m_axil_rresp;
                m_axil_rready                                  = s_axil_rready[rgrant_q];
                if (m_axil_rvalid && s_axil_rready[rgrant_q]) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // A requester must hold its address valid until accepted.
    for (genvar i = 0; i < NUM_S; i++) begin : g_valid_hold
        a_aw_hold: assert property (@(posedge aclk) disable iff (!aresetn)
            (s_axil_awvalid[i] && !s_axil_awready[i]) |=> s_axil_awvalid[i]);
        a_ar_hold: assert property (@(posedge aclk) disable iff (!aresetn)
            (s_axil_arvalid[i] && !s_axil_arready[i]) |=> s_axil_arvalid[i]);
    end

endmodule

// File: tb/tb_axil_arbiter.sv
// Directed bench for axil_arbiter (NUM_S=2); B/R responses are checked against a scoreboard queue.
module tb_axil_arbiter;

    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              aclk;
    logic              aresetn;
    logic [NS*AW-1:0]  s_axil_awaddr;
    logic [NS*3-1:0]   s_axil_awprot;
    logic [NS-1:0]     s_axil_awvalid;
    logic [NS-1:0]     s_axil_awready;
    logic [NS*DW-1:0]  s_axil_wdata;
    logic [NS*SW-1:0]  s_axil_wstrb;
    logic [NS-1:0]     s_axil_wvalid;
    logic [NS-1:0]     s_axil_wready;
    logic [NS*2-1:0]   s_axil_bresp;
    logic [NS-1:0]     s_axil_bvalid;
    logic [NS-1:0]     s_axil_bready;
    logic [NS*AW-1:0]  s_axil_araddr;
    logic [NS*3-1:0]   s_axil_arprot;
    logic [NS-1:0]     s_axil_arvalid;
    logic [NS-1:0]     s_axil_arready;
    logic [NS*DW-1:0]  s_axil_rdata;
    logic [NS*2-1:0]   s_axil_rresp;
    logic [NS-1:0]     s_axil_rvalid;
    logic [NS-1:0]     s_axil_rready;
    logic [AW-1:0]     m_axil_awaddr;
    logic [2:0]        m_axil_awprot;
    logic              m_axil_awvalid;
    logic              m_axil_awready;
    logic [DW-1:0]     m_axil_wdata;
    logic [SW-1:0]     m_axil_wstrb;
    logic              m_axil_wvalid;
    logic              m_axil_wready;
    logic [1:0]        m_axil_bresp;
    logic              m_axil_bvalid;
    logic              m_axil_bready;
    logic [AW-1:0]     m_axil_araddr;
    logic [2:0]        m_axil_arprot;
    logic              m_axil_arvalid;
    logic              m_axil_arready;
    logic [DW-1:0]     m_axil_rdata;
    logic [1:0]        m_axil_rresp;
    logic              m_axil_rvalid;
    logic              m_axil_rready;

    axil_arbiter #(.NUM_S(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int         port;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   rd_order[$];
    int   rem[NS];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic cyc();
        @(posedge aclk);
        #2;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.port = p;
        e.data = d;
        e.resp = r;
        sb_q.push_back(e);
    endtask

    task automatic check_b();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_b_underflow: observed empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            check("b_valid", s_axil_bvalid, 64'(1 << e.port));
            check("b_resp", s_axil_bresp[e.port*2 +: 2], e.resp);
            check("b_resp_other", s_axil_bresp[(1-e.port)*2 +: 2], 2'b00);
        end
    endtask

    task automatic check_r();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_r_underflow: observed empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            check("r_valid", s_axil_rvalid, 64'(1 << e.port));
            check("r_data", s_axil_rdata[e.port*DW +: DW], e.data);
            check("r_resp", s_axil_rresp[e.port*2 +: 2], e.resp);
            check("r_data_other", s_axil_rdata[(1-e.port)*DW +: DW], 32'h0);
        end
    endtask

    task automatic set_aw(input int p, input logic v, input logic [31:0] a);
        s_axil_awvalid[p]        = v;
        s_axil_awaddr[p*AW +: AW] = a;
    endtask

    task automatic set_w(input int p, input logic v, input logic [31:0] d);
        s_axil_wvalid[p]        = v;
        s_axil_wdata[p*DW +: DW] = d;
        s_axil_wstrb[p*SW +: SW] = v ? 4'hF : 4'h0;
    endtask

    task automatic set_ar(input int p, input logic v, input logic [31:0] a);
        s_axil_arvalid[p]        = v;
        s_axil_araddr[p*AW +: AW] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  p;
        bit  seen;

        aresetn = 1'b0;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = '0;
        s_axil_wdata = '0;  s_axil_wstrb = '0;  s_axil_wvalid = '0;
        s_axil_bready = '0; s_axil_araddr = '0; s_axil_arprot = '0;
        s_axil_arvalid = '0; s_axil_rready = '0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = 2'b00;
        m_axil_bvalid = 1'b0; m_axil_arready = 1'b0; m_axil_rdata = '0;
        m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;

        // Reset state
        cyc(); cyc();
        check("rst_m_awvalid", m_axil_awvalid, 1'b0);
        check("rst_m_wvalid", m_axil_wvalid, 1'b0);
        check("rst_m_arvalid", m_axil_arvalid, 1'b0);
        check("rst_m_bready", m_axil_bready, 1'b0);
        check("rst_m_rready", m_axil_rready, 1'b0);
        check("rst_s_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 6'b0);
        check("rst_s_valid", {s_axil_bvalid, s_axil_rvalid}, 4'b0);
        check("rst_m_awaddr", m_axil_awaddr, 32'h0);
        aresetn = 1'b1;

        // Single write from port 0
        cyc();
        set_aw(0, 1'b1, 32'h10);
        set_w(0, 1'b1, 32'hDEADBEEF);
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; s_axil_bready = 2'b11;
        push_exp(0, 32'h0, 2'b00);
        look();
        check("t1_grant_latency", m_axil_awvalid, 1'b0);
        cyc(); look();
        check("t1_m_awvalid", m_axil_awvalid, 1'b1);
        check("t1_m_awaddr", m_axil_awaddr, 32'h10);
        check("t1_m_wdata", m_axil_wdata, 32'hDEADBEEF);
        check("t1_m_wstrb", m_axil_wstrb, 4'hF);
        check("t1_s_awready", s_axil_awready, 2'b01);
        check("t1_s_wready", s_axil_wready, 2'b01);
        cyc();
        set_aw(0, 1'b0, 32'h0); set_w(0, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
        look();
        check("t1_m_awvalid_resp", m_axil_awvalid, 1'b0);
        check("t1_m_bready", m_axil_bready, 1'b1);
        check_b();
        cyc();
        m_axil_bvalid = 1'b0;
        look();
        check("t1_b_done", s_axil_bvalid, 2'b00);

        // Contended reads
`ifdef AXIL_ARB_FIXED_PRIO_EN
        rd_order = '{0, 0, 0, 0, 1};
        rem[0] = 4; rem[1] = 1;
`else
        rd_order = '{0, 1, 0, 1};
        rem[0] = 2; rem[1] = 2;
`endif
        cyc();
        set_ar(0, 1'b1, 32'h100);
        set_ar(1, 1'b1, 32'h104);
        m_axil_arready = 1'b1; s_axil_rready = 2'b11;
        look();
        for (int n = 0; n < rd_order.size(); n++) begin
            p    = rd_order[n];
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (m_axil_arvalid === 1'b1) seen = 1'b1;
                else begin cyc(); look(); end
            end
            check("t2_ar_wait", seen, 1'b1);
            check("t2_ar_grant", s_axil_arready, 64'(1 << p));
            check("t2_ar_addr", m_axil_araddr, (p == 1) ? 32'h104 : 32'h100);
            cyc();
            rem[p]--;
            if (rem[p] == 0) set_ar(p, 1'b0, 32'h0);
            m_axil_rvalid = 1'b1; m_axil_rdata = 32'hA0 + 32'(n); m_axil_rresp = 2'b00;
            push_exp(p, 32'hA0 + 32'(n), 2'b00);
            look();
            check_r();
            cyc();
            m_axil_rvalid = 1'b0; m_axil_rdata = '0;
            look();
        end

        // W accepted three cycles before AW on port 1
        cyc();
        set_aw(1, 1'b1, 32'h30);
        set_w(1, 1'b1, 32'h12345678);
        m_axil_awready = 1'b0; m_axil_wready = 1'b1;
        push_exp(1, 32'h0, 2'b10);
        cyc(); look();
        check("t3_aw_stall", s_axil_awready, 2'b00);
        check("t3_s_wready", s_axil_wready, 2'b10);
        cyc();
        set_w(1, 1'b0, 32'h0);
        look();
        check("t3_w_done", m_axil_wvalid, 1'b0);
        check("t3_aw_pending", m_axil_awvalid, 1'b1);
        check("t3_not_resp", m_axil_bready, 1'b0);
        cyc(); cyc();
        m_axil_awready = 1'b1;
        look();
        check("t3_s_awready", s_axil_awready, 2'b10);
        check("t3_m_awaddr", m_axil_awaddr, 32'h30);
        cyc();
        set_aw(1, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
        look();
        check("t3_m_bready", m_axil_bready, 1'b1);
        check_b();
        cyc();
        m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;

        // Concurrent write (port 0) and read (port 1)
        set_aw(0, 1'b1, 32'h20); set_w(0, 1'b1, 32'h0BADF00D);
        set_ar(1, 1'b1, 32'h24);
        m_axil_wready = 1'b1;
        cyc(); look();
        check("t4_both_active", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b111);
        check("t4_m_awaddr", m_axil_awaddr, 32'h20);
        check("t4_m_araddr", m_axil_araddr, 32'h24);
        check("t4_s_awready", s_axil_awready, 2'b01);
        check("t4_s_arready", s_axil_arready, 2'b10);
        cyc();
        set_aw(0, 1'b0, 32'h0); set_w(0, 1'b0, 32'h0); set_ar(1, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'h5555AAAA; m_axil_rresp = 2'b10;
        push_exp(0, 32'h0, 2'b00);
        push_exp(1, 32'h5555AAAA, 2'b10);
        look();
        check_b();
        check_r();
        cyc();
        m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00;

        // Slow B on port 0 holds off port 1
        set_aw(0, 1'b1, 32'h200); set_w(0, 1'b1, 32'h11112222);
        cyc(); look();
        check("t5_grant0", s_axil_awready, 2'b01);
        cyc();
        set_aw(0, 1'b0, 32'h0); set_w(0, 1'b0, 32'h0);
        set_aw(1, 1'b1, 32'h240); set_w(1, 1'b1, 32'h33334444);
        for (int k = 0; k < 10; k++) begin
            look();
            check("t5_held_awready", s_axil_awready, 2'b00);
            check("t5_held_awvalid", m_axil_awvalid, 1'b0);
            cyc();
        end
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
        push_exp(0, 32'h0, 2'b00);
        look();
        check_b();
        cyc();
        m_axil_bvalid = 1'b0;
        look();
        check("t5_idle_gap", m_axil_awvalid, 1'b0);
        cyc(); look();
        check("t5_grant1", s_axil_awready, 2'b10);
        check("t5_m_awaddr", m_axil_awaddr, 32'h240);
        check("t5_m_wdata", m_axil_wdata, 32'h33334444);
        cyc();
        set_aw(1, 1'b0, 32'h0); set_w(1, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
        push_exp(1, 32'h0, 2'b10);
        look();
        check_b();
        cyc();
        m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;

        // Reset while in W_RESP
        s_axil_bready = 2'b00;
        set_aw(0, 1'b1, 32'h300); set_w(0, 1'b1, 32'h77778888);
        cyc(); cyc();
        set_aw(0, 1'b0, 32'h0); set_w(0, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1;
        look();
        check("t6_pre_rst_bvalid", s_axil_bvalid, 2'b01);
        #1 aresetn = 1'b0;
        #1;
        check("t6_rst_bvalid", s_axil_bvalid, 2'b00);
        check("t6_rst_bready", m_axil_bready, 1'b0);
        check("t6_rst_awvalid", m_axil_awvalid, 1'b0);
        cyc(); cyc();
        aresetn = 1'b1;
        s_axil_bready = 2'b11;
        look();
        check("t6_no_replay", s_axil_bvalid, 2'b00);
        check("t6_no_replay_bready", m_axil_bready, 1'b0);
        cyc();
        m_axil_bvalid = 1'b0;
        set_aw(0, 1'b1, 32'h400); set_w(0, 1'b1, 32'hCAFE0000);
        set_aw(1, 1'b1, 32'h440); set_w(1, 1'b1, 32'hCAFE0001);
        cyc(); look();
        check("t6_first_grant", s_axil_awready, 2'b01);
        check("t6_first_addr", m_axil_awaddr, 32'h400);
        cyc();
        set_aw(0, 1'b0, 32'h0); set_w(0, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
        push_exp(0, 32'h0, 2'b00);
        look();
        check_b();
        cyc();
        m_axil_bvalid = 1'b0;
        cyc(); look();
        check("t6_second_grant", s_axil_awready, 2'b10);
        cyc();
        set_aw(1, 1'b0, 32'h0); set_w(1, 1'b0, 32'h0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
        push_exp(1, 32'h0, 2'b10);
        look();
        check_b();
        cyc();
        m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        look();

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_arbiter.md
Name: axil_arbiter

Overview:
- Shares one AXI-Lite master port among NUM_S AXI-Lite slave ports (requesters), e.g. CPU and DMA into one peripheral bus.
- Write and read paths are arbitrated independently.
- Each path uses a round-robin grant and allows one outstanding transaction.
- Sits between requester masters and the peripheral interconnect.

Parameters:
- NUM_S, 2, number of requester ports (2..8)
- ADDR_WIDTH, 32, AXI-Lite address width
- DATA_WIDTH, 32, AXI-Lite data width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous reset, active low
- s_axil_awaddr  in  NUM_S*ADDR_WIDTH  per-requester write address, requester i at slice i
- s_axil_awprot  in  NUM_S*3  write prot
- s_axil_awvalid / s_axil_awready  in / out  NUM_S  AW handshake
- s_axil_wdata  in  NUM_S*DATA_WIDTH  write data
- s_axil_wstrb  in  NUM_S*STRB_WIDTH  write strobes
- s_axil_wvalid / s_axil_wready  in / out  NUM_S  W handshake
- s_axil_bresp  out  NUM_S*2  write response
- s_axil_bvalid / s_axil_bready  out / in  NUM_S  B handshake
- s_axil_araddr  in  NUM_S*ADDR_WIDTH  read address
- s_axil_arprot  in  NUM_S*3  read prot
- s_axil_arvalid / s_axil_arready  in / out  NUM_S  AR handshake
- s_axil_rdata  out  NUM_S*DATA_WIDTH  read data
- s_axil_rresp  out  NUM_S*2  read response
- s_axil_rvalid / s_axil_rready  out / in  NUM_S  R handshake
- m_axil_*  out/in  full AXI-Lite master: awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready

Behaviour:
- Reset, asynchronous:
  - both FSMs to IDLE; all valid/ready outputs 0; all data/resp outputs 0.
  - wgrant = rgrant = 0; last-granted pointers = NUM_S-1, so requester 0 wins first.
  - Reset mid-transaction abandons it; no response is replayed after release.
- Write FSM, states W_IDLE, W_XFER, W_RESP:
  - W_IDLE: request vector = s_axil_awvalid. If nonzero, pick the first set bit searching from last_w+1 upward with wrap. Register wgrant, set last_w = wgrant, clear aw_done/w_done, go to W_XFER (1 cycle grant latency).
  - W_XFER: m_axil_aw* = granted slice. m_axil_awvalid = s_awvalid[g] & !aw_done; s_axil_awready[g] = m_axil_awready & !aw_done. Same pattern for W with w_done. AW and W may complete in the same or different cycles, in either order. When both are done (registered or current-cycle handshake), go to W_RESP.
  - W_RESP: s_axil_bvalid[g] = m_axil_bvalid; m_axil_bready = s_axil_bready[g]; bresp routed to slice g. On B handshake go to W_IDLE. The next grant can issue the following cycle.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - Same pattern using s_axil_arvalid and last_r.
  - R_ADDR forwards AR until its handshake, then R_DATA.
  - R_DATA routes R to rgrant; on R handshake go to R_IDLE.
- Non-granted ports: ready/valid outputs 0; rdata/rresp/bresp slices 0.
- Master port outside XFER/ADDR: m_axil_awvalid = m_axil_wvalid = m_axil_arvalid = 0.
- All routing is combinational on the registered grant. No buffering; single-cycle pass-through.
- A requester keeps its grant until its response handshake completes. A held-off requester's valid is simply not acknowledged.
- Read and write paths run concurrently and may serve different requesters. Read/write ordering across paths is not guaranteed.
- Round-robin wrap: last = NUM_S-1 makes search start at 0.
- A requester that drops awvalid before its grant is not granted. Requesters must not do this (AXI rule); an assertion flags it.

Optional Feature:
- AXIL_ARB_FIXED_PRIO_EN
- Defined: the arbiter always picks the lowest-index requesting port; last-granted pointers are removed.
- Undefined (default): round-robin as above.
- Handshake and FSM behaviour are identical in both cases.

Decomposition:
- Package axil_arb_pkg: write_state_t, read_state_t enums; RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10 constants; function for clog2-sized grant index width.
- Sub-module axil_rr_picker: combinational picker (request vector, last pointer -> grant index, any_req; fixed-priority variant under the macro). Instantiated twice, once for writes and once for reads.

Test Plan:
- Single write from port 0, awaddr 0x10, wdata 0xDEADBEEF, m_axil_bresp 2'b00 -> master sees the same addr/data; port 0 gets bvalid with bresp 2'b00; port 1 sees no activity.
- Ports 0 and 1 both assert arvalid continuously for 4 reads -> grants alternate 0,1,0,1. Each rdata (0xA0+n) is returned only to the granted port.
- W arrives 3 cycles before AW on port 1 -> W handshake first, AW later, single B to port 1; FSM W_XFER->W_RESP only after both.
- Concurrent: port 0 writes 0x20 while port 1 reads 0x24 -> both master channels active in the same cycles, responses routed correctly.
- Master holds bvalid low 10 cycles; port 1 requests a write meanwhile -> port 1 granted only after port 0's B handshake.
- aresetn asserted in W_RESP -> all valids drop immediately; after release port 0 wins the first grant. With AXIL_ARB_FIXED_PRIO_EN: port 0 wins all 4 contended reads.
